// File: rtl/debug_host_loader_if.sv
// Byte-level link bundle of the debug host loader: program ROM, command input,
// tx/rx UART byte handshakes and capture-RAM write port.
interface debug_host_loader_if #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 7,
  parameter int N_BITS       = 8,
  parameter int NB_DUMP_ADDR = 8
);
  logic                    start_i;
  logic [NB_ADDR:0]        prog_len_i;
  logic [NB_ADDR-1:0]      prog_addr_o;
  logic [NB_DATA-1:0]      prog_data_i;
  logic                    cmd_valid_i;
  logic [N_BITS-1:0]       cmd_mode_i;
  logic [N_BITS-1:0]       tx_din_o;
  logic                    tx_start_o;
  logic                    tx_ready_i;
  logic [N_BITS-1:0]       rx_dout_i;
  logic                    rx_done_i;
  logic                    dump_we_o;
  logic [NB_DUMP_ADDR-1:0] dump_addr_o;
  logic [NB_DATA-1:0]      dump_data_o;
  logic                    busy_o;
  logic                    load_done_o;
  logic                    dump_done_o;
  logic                    error_o;

  modport master (
    input  start_i, prog_len_i, prog_data_i, cmd_valid_i, cmd_mode_i,
           tx_ready_i, rx_dout_i, rx_done_i,
    output prog_addr_o, tx_din_o, tx_start_o, dump_we_o, dump_addr_o,
           dump_data_o, busy_o, load_done_o, dump_done_o, error_o
  );

  modport slave (
    output start_i, prog_len_i, prog_data_i, cmd_valid_i, cmd_mode_i,
           tx_ready_i, rx_dout_i, rx_done_i,
    input  prog_addr_o, tx_din_o, tx_start_o, dump_we_o, dump_addr_o,
           dump_data_o, busy_o, load_done_o, dump_done_o, error_o
  );
endinterface

// File: rtl/debug_host_loader.sv
// Host side of the MIPS debug UART link: streams a program LSB-byte-first, sends
// mode bytes and captures the register/memory dump. Macro DEBUG_HOST_TIMEOUT_EN adds a dump inactivity timeout.
module debug_host_loader #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 7,
  parameter int N_BITS       = 8,
  parameter int N_REGISTER   = 32,
  parameter int N_MEM_WORDS  = 127,
  parameter int NB_DUMP_ADDR = 8
`ifdef DEBUG_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  debug_host_loader_if.master  bus
);
  localparam int LAST_IDX = N_REGISTER + N_MEM_WORDS - 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND_WORD, SEND_TERM, WAIT_CMD, SEND_MODE, RECV_DUMP
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_tx_ph;      // 0: may start, 1: wait ready low, 2: wait ready high
  logic [1:0]              r_byte;
  logic                    r_fetch_wait;
  logic [NB_ADDR:0]        r_len;
  logic [NB_ADDR:0]        r_cnt;
  logic [NB_DATA-1:0]      r_word;
  logic [N_BITS-1:0]       r_mode;
  logic [NB_DATA-1:0]      r_dword;
  logic [1:0]              r_rbyte;
  logic [NB_DUMP_ADDR-1:0] r_widx;
  logic                    r_done_pend;
  logic [NB_ADDR-1:0]      r_prog_addr;
  logic [N_BITS-1:0]       r_tx_din;
  logic                    r_tx_start;
  logic                    r_dump_we;
  logic [NB_DUMP_ADDR-1:0] r_dump_addr;
  logic [NB_DATA-1:0]      r_dump_data;
  logic                    r_load_done;
  logic                    r_dump_done;
  logic                    r_error;
`ifdef DEBUG_HOST_TIMEOUT_EN
  logic [31:0]             r_tmo;
`endif

  logic                    w_issue;
  logic                    w_byte_done;
  logic [NB_ADDR:0]        w_cnt_nxt;
  logic [NB_DATA-1:0]      w_dword_nxt;

  assign w_issue     = (r_tx_ph == 2'd0) && bus.tx_ready_i;
  assign w_byte_done = (r_tx_ph == 2'd2) && bus.tx_ready_i;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_dword_nxt = {bus.rx_dout_i, r_dword[NB_DATA-1:N_BITS]};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_tx_ph      <= 2'd0;
      r_byte       <= 2'd0;
      r_fetch_wait <= 1'b0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_mode       <= '0;
      r_dword      <= '0;
      r_rbyte      <= 2'd0;
      r_widx       <= '0;
      r_done_pend  <= 1'b0;
      r_prog_addr  <= '0;
      r_tx_din     <= '0;
      r_tx_start   <= 1'b0;
      r_dump_we    <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_load_done  <= 1'b0;
      r_dump_done  <= 1'b0;
      r_error      <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      r_tx_start  <= 1'b0;
      r_dump_we   <= 1'b0;
      r_dump_done <= 1'b0;

      // Shared tx handshake: start only when ready, then see ready fall and rise again
      if (r_state == SEND_WORD || r_state == SEND_TERM || r_state == SEND_MODE) begin
        case (r_tx_ph)
          2'd0:    if (bus.tx_ready_i) begin r_tx_start <= 1'b1; r_tx_ph <= 2'd1; end
          2'd1:    if (!bus.tx_ready_i) r_tx_ph <= 2'd2;
          default: if (bus.tx_ready_i) r_tx_ph <= 2'd0;
        endcase
      end

      case (r_state)
        IDLE, WAIT_CMD: begin
          if (bus.start_i) begin
            r_load_done  <= 1'b0;
            r_error      <= 1'b0;
            r_len        <= bus.prog_len_i;
            r_cnt        <= '0;
            r_prog_addr  <= '0;
            r_byte       <= 2'd0;
            r_tx_ph      <= 2'd0;
            r_fetch_wait <= 1'b0;
            r_state      <= (bus.prog_len_i == '0) ? SEND_TERM : FETCH;
          end else if (r_state == WAIT_CMD && bus.cmd_valid_i) begin
            r_mode  <= bus.cmd_mode_i;
            r_tx_ph <= 2'd0;
            r_state <= SEND_MODE;
          end
        end
        FETCH: begin
          if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_fetch_wait <= 1'b0;
            // An all-ones program word would be read by the target as the terminator
            if (&bus.prog_data_i) begin
              r_error <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_word  <= bus.prog_data_i;
              r_byte  <= 2'd0;
              r_state <= SEND_WORD;
            end
          end
        end
        SEND_WORD: begin
          if (w_issue) begin
            r_tx_din <= r_word[N_BITS-1:0];
            r_word   <= r_word >> N_BITS;
          end
          if (w_byte_done) begin
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == r_len) begin
                r_state <= SEND_TERM;
              end else begin
                r_prog_addr <= w_cnt_nxt[NB_ADDR-1:0];
                r_state     <= FETCH;
              end
            end
          end
        end
        SEND_TERM: begin
          if (w_issue) r_tx_din <= '1;
          if (w_byte_done) begin
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              r_load_done <= 1'b1;
              r_state     <= WAIT_CMD;
            end
          end
        end
        SEND_MODE: begin
          if (w_issue) r_tx_din <= r_mode;
          if (w_byte_done) begin
            if (r_mode == N_BITS'(1)) begin
              r_rbyte     <= 2'd0;
              r_widx      <= '0;
              r_done_pend <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
              r_tmo       <= '0;
`endif
              r_state     <= RECV_DUMP;
            end else begin
              r_state <= WAIT_CMD;
            end
          end
        end
        RECV_DUMP: begin
          if (r_done_pend) begin
            r_done_pend <= 1'b0;
            r_dump_done <= 1'b1;
            r_state     <= WAIT_CMD;
          end else if (bus.rx_done_i) begin
            r_dword <= w_dword_nxt;
            r_rbyte <= r_rbyte + 2'd1;
`ifdef DEBUG_HOST_TIMEOUT_EN
            r_tmo   <= '0;
`endif
            if (r_rbyte == 2'd3) begin
              r_dump_we   <= 1'b1;
              r_dump_addr <= r_widx;
              r_dump_data <= w_dword_nxt;
              r_widx      <= r_widx + 1'b1;
              if (r_widx == NB_DUMP_ADDR'(LAST_IDX)) r_done_pend <= 1'b1;
            end
          end
`ifdef DEBUG_HOST_TIMEOUT_EN
          else if (r_tmo == 32'(TIMEOUT_CYCLES - 1)) begin
            r_error <= 1'b1;
            r_rbyte <= 2'd0;
            r_state <= WAIT_CMD;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.prog_addr_o = r_prog_addr;
  assign bus.tx_din_o    = r_tx_din;
  assign bus.tx_start_o  = r_tx_start;
  assign bus.dump_we_o   = r_dump_we;
  assign bus.dump_addr_o = r_dump_addr;
  assign bus.dump_data_o = r_dump_data;
  assign bus.busy_o      = (r_state != IDLE) && (r_state != WAIT_CMD);
  assign bus.load_done_o = r_load_done;
  assign bus.dump_done_o = r_dump_done;
  assign bus.error_o     = r_error;
endmodule

// File: tb/tb_debug_host_loader.sv
// Bench for debug_host_loader: program-load vector table plus hand sequences for
// commands, full dump, async reset mid-dump and (with DEBUG_HOST_TIMEOUT_EN) the dump timeout.
module tb_debug_host_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_host_loader_if #(.NB_DATA(32), .NB_ADDR(7), .N_BITS(8), .NB_DUMP_ADDR(8)) bus ();

  debug_host_loader #(
    .NB_DATA(32), .NB_ADDR(7), .N_BITS(8), .N_REGISTER(32), .N_MEM_WORDS(127), .NB_DUMP_ADDR(8)
`ifdef DEBUG_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_tx = 0;
  int n_writes = 0;
  int n_done = 0;
  int max_addr = 0;
  logic [7:0]  txq [$];
  logic [39:0] dq [$];   // {addr, data}
  logic [31:0] rom [0:127];

  typedef struct {
    logic [7:0]       len;
    logic [3:0][31:0] w;
    int               n_sent;
    bit               term;
    bit               err;
  } load_vec_t;
  load_vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic bound_check(input string name, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired, got no completion, required completion", name);
    end
  endtask

  // Synchronous program ROM
  always @(posedge clk) bus.prog_data_i <= rom[bus.prog_addr_o];

  // Transmitter model: ready drops after each start and returns 10 cycles later
  initial begin
    logic [7:0] cur;
    bit stable;
    bus.tx_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tx_start_o === 1'b1) begin
        n_tx++;
        cur = bus.tx_din_o;
        if (txq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected_byte: got %0h, required no byte", cur);
        end else begin
          check("tx_byte", cur, txq.pop_front());
        end
        bus.tx_ready_i = 1'b0;
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (bus.tx_din_o !== cur || bus.tx_start_o !== 1'b0) stable = 1'b0;
        end
        bus.tx_ready_i = 1'b1;
        check("tx_din_stable_no_restart", stable, 1'b1);
      end
    end
  end

  // Capture monitor and dump_done placement
  initial begin
    logic [39:0] e;
    bit          we_prev = 1'b0;
    logic [7:0]  last_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.prog_addr_o > max_addr) max_addr = bus.prog_addr_o;
      if (bus.dump_done_o === 1'b1) begin
        n_done++;
        check("dump_done_after_last_write", {we_prev, last_addr}, {1'b1, 8'd158});
      end
      if (bus.dump_we_o === 1'b1) begin
        n_writes++;
        last_addr = bus.dump_addr_o;
        if (dq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL dump_unexpected_write: got addr %0d, required no write", bus.dump_addr_o);
        end else begin
          e = dq.pop_front();
          check("dump_addr", bus.dump_addr_o, e[39:32]);
          check("dump_data", bus.dump_data_o, e[31:0]);
        end
      end
      we_prev = (bus.dump_we_o === 1'b1);
    end
  end

  task automatic pulse_start(input logic [7:0] len, input bit with_cmd);
    @(negedge clk);
    bus.start_i = 1'b1; bus.prog_len_i = len;
    bus.cmd_valid_i = with_cmd; bus.cmd_mode_i = 8'h02;
    @(negedge clk);
    bus.start_i = 1'b0; bus.cmd_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_cmd(input logic [7:0] mode);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_mode_i = mode;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_not_busy(input string name, input int lim);
    int i = 0;
    while (bus.busy_o && i < lim) begin @(negedge clk); i++; end
    bound_check(name, i < lim);
  endtask

  task automatic wait_tx_drain(input string name);
    int i = 0;
    while ((txq.size() != 0 || !bus.tx_ready_i) && i < 2000) begin @(negedge clk); i++; end
    bound_check(name, i < 2000);
    repeat (3) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dout_i = b; bus.rx_done_i = 1'b1;
    @(negedge clk);
    bus.rx_done_i = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) txq.push_back(w[8*b +: 8]);
  endtask

  initial begin
    int base;
    int i;
    logic [31:0] kw;
    bus.start_i = 0; bus.prog_len_i = '0; bus.cmd_valid_i = 0; bus.cmd_mode_i = '0;
    bus.rx_dout_i = '0; bus.rx_done_i = 0;
    for (int k = 0; k < 128; k++) rom[k] = 32'h0;

    vecs[0].len = 8'd2; vecs[0].n_sent = 2; vecs[0].term = 1; vecs[0].err = 0;
    vecs[0].w[0] = 32'h8C010004; vecs[0].w[1] = 32'h00221820; vecs[0].w[2] = 0; vecs[0].w[3] = 0;
    vecs[1].len = 8'd0; vecs[1].n_sent = 0; vecs[1].term = 1; vecs[1].err = 0;
    vecs[1].w = '0;
    vecs[2].len = 8'd4; vecs[2].n_sent = 4; vecs[2].term = 1; vecs[2].err = 0;
    vecs[2].w[0] = 32'hA5A50F0F; vecs[2].w[1] = 32'h12345678; vecs[2].w[2] = 32'hDEADBEEF; vecs[2].w[3] = 32'h00000000;
    vecs[3].len = 8'd3; vecs[3].n_sent = 1; vecs[3].term = 0; vecs[3].err = 1;
    vecs[3].w[0] = 32'h11111111; vecs[3].w[1] = 32'hFFFFFFFF; vecs[3].w[2] = 32'h22222222; vecs[3].w[3] = 0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_start", bus.tx_start_o, 1'b0);
    check("reset_busy", bus.busy_o, 1'b0);
    check("reset_flags", {bus.load_done_o, bus.dump_done_o, bus.error_o, bus.dump_we_o}, 4'h0);
    check("reset_buses", {bus.prog_addr_o, bus.tx_din_o, bus.dump_addr_o, bus.dump_data_o}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 4; j++) rom[j] = vecs[v].w[j];
      for (int j = 0; j < vecs[v].n_sent; j++) push_word(vecs[v].w[j]);
      if (vecs[v].term) push_word(32'hFFFFFFFF);
      pulse_start(vecs[v].len, 1'b0);
      wait_not_busy("load_vec_finish", 3000);
      repeat (2) @(negedge clk);
      check("load_vec_bytes_left", txq.size(), 0);
      check("load_vec_load_done", bus.load_done_o, vecs[v].term);
      check("load_vec_error", bus.error_o, vecs[v].err);
    end

    // In IDLE after the bad-word error: commands are ignored
    base = n_tx;
    pulse_cmd(8'h02);
    repeat (20) @(negedge clk);
    check("idle_cmd_ignored", n_tx - base, 0);

    // Full 128-word program: last address reached, no wrap; start clears error
    for (int k = 0; k < 128; k++) begin
      rom[k] = k * 32'h00010003 + 32'h1;
      push_word(rom[k]);
    end
    push_word(32'hFFFFFFFF);
    max_addr = 0;
    pulse_start(8'd128, 1'b0);
    check("maxlen_error_cleared", bus.error_o, 1'b0);
    wait_not_busy("maxlen_finish", 20000);
    repeat (2) @(negedge clk);
    check("maxlen_bytes_left", txq.size(), 0);
    check("maxlen_last_addr", max_addr, 127);
    check("maxlen_load_done", bus.load_done_o, 1'b1);

    // Continue mode: one byte, back to WAIT_CMD, stray rx bytes discarded
    base = n_writes;
    txq.push_back(8'h02);
    pulse_cmd(8'h02);
    wait_not_busy("cmd02_finish", 500);
    rx_byte(8'h77);
    rx_byte(8'h66);
    repeat (5) @(negedge clk);
    check("cmd02_bytes_left", txq.size(), 0);
    check("cmd02_no_writes", n_writes - base, 0);
    check("cmd02_busy", bus.busy_o, 1'b0);

    // start and cmd together in WAIT_CMD: start wins (terminator only, no mode byte)
    push_word(32'hFFFFFFFF);
    pulse_start(8'd0, 1'b1);
    wait_not_busy("start_wins_finish", 1000);
    repeat (2) @(negedge clk);
    check("start_wins_bytes_left", txq.size(), 0);
    check("start_wins_load_done", bus.load_done_o, 1'b1);

    // Step mode: full 159-word dump
    base = n_writes;
    txq.push_back(8'h01);
    pulse_cmd(8'h01);
    wait_tx_drain("step_mode_tx");
    check("step_busy_in_dump", bus.busy_o, 1'b1);
    for (int k = 0; k < 159; k++) begin
      kw = k * 32'h01010101;
      dq.push_back({8'(k), kw});
      for (int b = 0; b < 4; b++) rx_byte(kw[8*b +: 8]);
    end
    i = 0;
    while (n_done == 0 && i < 20) begin @(negedge clk); i++; end
    bound_check("dump_done_seen", i < 20);
    repeat (3) @(negedge clk);
    check("dump_write_count", n_writes - base, 159);
    check("dump_done_count", n_done, 1);
    check("dump_queue_left", dq.size(), 0);
    check("dump_busy_after", bus.busy_o, 1'b0);

`ifdef DEBUG_HOST_TIMEOUT_EN
    // Stalled dump: error after TIMEOUT_CYCLES, partial word dropped
    base = n_writes;
    txq.push_back(8'h01);
    pulse_cmd(8'h01);
    wait_tx_drain("tmo_mode_tx");
    rx_byte(8'h12);
    rx_byte(8'h34);
    i = 0;
    while (bus.busy_o && i < 300) begin @(negedge clk); i++; end
    bound_check("tmo_exit", i < 300);
    check("tmo_latency_window", (i >= 95 && i <= 105), 1'b1);
    check("tmo_error", bus.error_o, 1'b1);
    check("tmo_no_write", n_writes - base, 0);
`endif

    // Async reset in the middle of word 40 of a dump
    txq.push_back(8'h01);
    pulse_cmd(8'h01);
    wait_tx_drain("reset_mode_tx");
    for (int k = 0; k < 40; k++) begin
      kw = k * 32'h01010101;
      dq.push_back({8'(k), kw});
      for (int b = 0; b < 4; b++) rx_byte(kw[8*b +: 8]);
    end
    rx_byte(8'h28);
    rx_byte(8'h28);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", bus.busy_o, 1'b0);
    check("midreset_flags", {bus.load_done_o, bus.dump_done_o, bus.error_o, bus.dump_we_o, bus.tx_start_o}, 5'h0);
    check("midreset_buses", {bus.prog_addr_o, bus.tx_din_o, bus.dump_addr_o, bus.dump_data_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    check("midreset_queue_left", dq.size(), 0);
    base = n_tx;
    pulse_cmd(8'h02);
    repeat (20) @(negedge clk);
    check("midreset_idle_cmd_ignored", n_tx - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
